// File: rtl/cronometro_bcd.sv
// cronometro_bcd: mm:ss stopwatch counting in BCD on synchronised ticks from the slow novo_clock
// Ports:
//   clock_50                          system clock
//   reset                             asynchronous reset, active-low
//   novo_clock                        slow divider output, sampled as data (rising edge = tick)
//   key_start_n                       start/stop pushbutton, active-low (falling edge = press)
//   key_clear_n                       clear pushbutton, active-low (level)
//   seg_uni, seg_dez, min_uni, min_dez BCD digits of mm:ss
//   running                           high while in RUN
//   wrap                              one-cycle pulse on MIN_MAX:59 -> 00:00
//   hex0..hex3                        active-low gfedcba patterns of the four digits
// Build option: SEVEN_SEG_EN selects a registered 7-seg decode; otherwise hex0..hex3 stay blank (7'h7F).
module cronometro_bcd #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_MAX     = 59
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       novo_clock,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  output logic [3:0] seg_uni,
  output logic [3:0] seg_dez,
  output logic [3:0] min_uni,
  output logic [3:0] min_dez,
  output logic       running,
  output logic       wrap,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam logic [3:0] MAX_DEZ = 4'(MIN_MAX / 10);
  localparam logic [3:0] MAX_UNI = 4'(MIN_MAX % 10);
  state_t state, state_nxt;
  // bit 0 is the first synchroniser stage, bit SYNC_STAGES-1 the synced value, bit SYNC_STAGES its history
  logic [SYNC_STAGES:0] nc_sr, ks_sr, kc_sr;
  logic tick, press, clr, step, at_max, c0, c1, c2;
  assign tick   = nc_sr[SYNC_STAGES-1] & ~nc_sr[SYNC_STAGES];
  assign press  = ~ks_sr[SYNC_STAGES-1] & ks_sr[SYNC_STAGES];
  assign clr    = ~kc_sr[SYNC_STAGES-1];
  assign step   = (state == RUN) & tick & ~clr;
  assign c0     = seg_uni == 4'd9;
  assign c1     = c0 & (seg_dez == 4'd5);
  assign c2     = c1 & (min_uni == 4'd9);
  assign at_max = c1 & (min_uni == MAX_UNI) & (min_dez == MAX_DEZ);
  always_comb state_nxt = clr ? IDLE : press ? ((state == RUN) ? PAUSE : RUN) : state;
  always_ff @(posedge clock_50 or negedge reset)
    if (!reset) begin
      nc_sr   <= '0;
      ks_sr   <= '0;
      kc_sr   <= '0;
      state   <= IDLE;
      running <= 1'b0;
      wrap    <= 1'b0;
      seg_uni <= '0;
      seg_dez <= '0;
      min_uni <= '0;
      min_dez <= '0;
    end else begin
      nc_sr   <= {nc_sr[SYNC_STAGES-1:0], novo_clock};
      ks_sr   <= {ks_sr[SYNC_STAGES-1:0], key_start_n};
      kc_sr   <= {kc_sr[SYNC_STAGES-1:0], key_clear_n};
      state   <= state_nxt;
      running <= state_nxt == RUN;
      wrap    <= step & at_max;
      if (clr || (step && at_max)) begin
        seg_uni <= '0;
        seg_dez <= '0;
        min_uni <= '0;
        min_dez <= '0;
      end else if (step) begin
        seg_uni <= c0 ? 4'd0 : seg_uni + 4'd1;
        seg_dez <= c1 ? 4'd0 : c0 ? seg_dez + 4'd1 : seg_dez;
        min_uni <= c2 ? 4'd0 : c1 ? min_uni + 4'd1 : min_uni;
        min_dez <= c2 ? min_dez + 4'd1 : min_dez;
      end
    end
`ifdef SEVEN_SEG_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction
  // reset value is the pattern for digit 0 so the display shows 00:00 during reset
  always_ff @(posedge clock_50 or negedge reset)
    if (!reset) begin
      hex0 <= 7'h40;
      hex1 <= 7'h40;
      hex2 <= 7'h40;
      hex3 <= 7'h40;
    end else begin
      hex0 <= seg7(seg_uni);
      hex1 <= seg7(seg_dez);
      hex2 <= seg7(min_uni);
      hex3 <= seg7(min_dez);
    end
`else
  assign hex0 = 7'h7F;
  assign hex1 = 7'h7F;
  assign hex2 = 7'h7F;
  assign hex3 = 7'h7F;
`endif
endmodule

// File: tb/tb_cronometro_bcd.sv
// tb_cronometro_bcd: self-checking bench for cronometro_bcd against a seconds-count reference model
module tb_cronometro_bcd;
  localparam int S    = 2;
  localparam int MM   = 1;
  localparam int MAXT = (MM + 1) * 60;
`ifdef SEVEN_SEG_EN
  localparam logic [6:0] SEG7 [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [27:0] HEX_ZERO = {4{7'h40}};
`else
  localparam logic [27:0] HEX_ZERO = {4{7'h7F}};
`endif
  logic clock_50 = 0, reset = 0, novo_clock = 0, key_start_n = 1, key_clear_n = 1;
  logic [3:0] seg_uni, seg_dez, min_uni, min_dez;
  logic running, wrap;
  logic [6:0] hex0, hex1, hex2, hex3;
  int errors = 0, checks = 0;
  cronometro_bcd #(.SYNC_STAGES(S), .MIN_MAX(MM)) dut (
    .clock_50(clock_50), .reset(reset), .novo_clock(novo_clock),
    .key_start_n(key_start_n), .key_clear_n(key_clear_n),
    .seg_uni(seg_uni), .seg_dez(seg_dez), .min_uni(min_uni), .min_dez(min_dez),
    .running(running), .wrap(wrap),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
  );
  always #5 clock_50 = ~clock_50;
  wire [17:0] dut_vec = {min_dez, min_uni, seg_dez, seg_uni, running, wrap};
  wire [27:0] dut_hex = {hex3, hex2, hex1, hex0};
  // Reference: an input sampled at edge j takes effect at edge j+S; the count is a plain number of seconds.
  typedef struct packed {int total; int mode; bit w;} mstate_t;
  mstate_t mdl;
  int ecnt;
  bit [15:0] r_nc, r_ks, r_kc;
  function automatic bit at(input bit [15:0] r, input int i);
    return (i < 0) ? 1'b0 : r[i[3:0]];
  endfunction
  function automatic mstate_t model_step(input mstate_t m, input bit tk, input bit pr, input bit cl);
    mstate_t n;
    n = m;
    n.w = 0;
    if (cl) begin
      n.total = 0;
      n.mode  = 0;
    end else begin
      if (m.mode == 1 && tk) begin
        n.total = (m.total + 1) % MAXT;
        n.w     = n.total == 0;
      end
      if (pr) n.mode = (m.mode == 1) ? 2 : 1;
    end
    return n;
  endfunction
  always @(posedge clock_50 or negedge reset)
    if (!reset) begin
      ecnt <= 0;
      mdl  <= '0;
    end else begin
      r_nc[ecnt[3:0]] <= novo_clock;
      r_ks[ecnt[3:0]] <= key_start_n;
      r_kc[ecnt[3:0]] <= key_clear_n;
      ecnt <= ecnt + 1;
      mdl  <= model_step(mdl,
                         at(r_nc, ecnt - S) && !at(r_nc, ecnt - S - 1),
                         !at(r_ks, ecnt - S) && at(r_ks, ecnt - S - 1),
                         !at(r_kc, ecnt - S));
    end
  function automatic logic [17:0] exp_vec();
    int sec, mn;
    sec = mdl.total % 60;
    mn  = mdl.total / 60;
    return {4'(mn / 10), 4'(mn % 10), 4'(sec / 10), 4'(sec % 10), mdl.mode == 1, mdl.w};
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(negedge clock_50);
  endtask
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      novo_clock = 1;
      cyc(2);
      novo_clock = 0;
      cyc(2);
    end
  endtask
  task automatic press_start();
    key_start_n = 0;
    cyc(2);
    key_start_n = 1;
    cyc(S + 2);
  endtask
  task automatic do_clear();
    key_clear_n = 0;
    cyc(S + 2);
    key_clear_n = 1;
    cyc(S + 2);
  endtask
  task automatic test_reset();
    cyc(1);
    checks++; if (dut_vec !== 18'd0) begin errors++; $display("FAIL reset_hold: got %h expected %h", dut_vec, 18'd0); end
    checks++; if (dut_hex !== HEX_ZERO) begin errors++; $display("FAIL reset_hex: got %h expected %h", dut_hex, HEX_ZERO); end
    cyc(2);
    reset = 1;
    cyc(S + 2);
    checks++; if (dut_vec !== 18'd0) begin errors++; $display("FAIL reset_release: got %h expected %h", dut_vec, 18'd0); end
    checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_model: got %h expected %h", dut_vec, exp_vec()); end
  endtask
  task automatic test_count();
    press_start();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL count_running: got %b expected 1", running); end
    novo_clock = 1;
    for (int k = 0; k <= S; k++) begin
      cyc(1);
      checks++; if (seg_uni !== ((k == S) ? 4'd1 : 4'd0)) begin errors++; $display("FAIL count_latency%0d: got %0d expected %0d", k, seg_uni, (k == S) ? 1 : 0); end
    end
    novo_clock = 0;
    cyc(2);
    tick_n(9);
    cyc(S + 1);
    checks++; if (dut_vec !== {4'd0, 4'd0, 4'd1, 4'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL count_10: got %h expected %h", dut_vec, {4'd0, 4'd0, 4'd1, 4'd0, 1'b1, 1'b0}); end
    checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL count_model: got %h expected %h", dut_vec, exp_vec()); end
  endtask
  task automatic test_wrap();
    int wcount;
    do_clear();
    checks++; if (dut_vec !== 18'd0) begin errors++; $display("FAIL wrap_clear: got %h expected 0", dut_vec); end
    press_start();
    tick_n(MAXT - 1);
    cyc(S + 1);
    checks++; if (dut_vec !== {4'd0, 4'd1, 4'd5, 4'd9, 1'b1, 1'b0}) begin errors++; $display("FAIL wrap_preload: got %h expected %h", dut_vec, {4'd0, 4'd1, 4'd5, 4'd9, 1'b1, 1'b0}); end
    wcount = 0;
    novo_clock = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) novo_clock = 0;
      cyc(1);
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL wrap_cycle%0d: got %h expected %h", i, dut_vec, exp_vec()); end
      if (wrap === 1'b1) begin
        wcount++;
        checks++; if (dut_vec !== {16'h0000, 1'b1, 1'b1}) begin errors++; $display("FAIL wrap_zero: got %h expected %h", dut_vec, {16'h0000, 1'b1, 1'b1}); end
      end
    end
    checks++; if (wcount != 1) begin errors++; $display("FAIL wrap_pulses: got %0d expected 1", wcount); end
  endtask
  task automatic test_pause_tick();
    tick_n(3);
    cyc(S + 1);
    checks++; if (dut_vec !== {4'd0, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0}) begin errors++; $display("FAIL pause_pre: got %h expected %h", dut_vec, {4'd0, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0}); end
    novo_clock = 1;
    key_start_n = 0;
    cyc(S + 1);
    checks++; if (dut_vec !== {4'd0, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0}) begin errors++; $display("FAIL pause_tick_press: got %h expected %h", dut_vec, {4'd0, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0}); end
    key_start_n = 1;
    novo_clock = 0;
    cyc(2);
    tick_n(5);
    cyc(S + 1);
    checks++; if (dut_vec !== {4'd0, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0}) begin errors++; $display("FAIL pause_hold: got %h expected %h", dut_vec, {4'd0, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0}); end
    checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL pause_model: got %h expected %h", dut_vec, exp_vec()); end
  endtask
  task automatic test_clear();
    press_start();
    tick_n(33);
    cyc(S + 1);
    checks++; if (dut_vec !== {4'd0, 4'd0, 4'd3, 4'd7, 1'b1, 1'b0}) begin errors++; $display("FAIL clear_pre: got %h expected %h", dut_vec, {4'd0, 4'd0, 4'd3, 4'd7, 1'b1, 1'b0}); end
    key_clear_n = 0;
    novo_clock = 1;
    cyc(S + 1);
    checks++; if (dut_vec !== 18'd0) begin errors++; $display("FAIL clear_apply: got %h expected 0", dut_vec); end
    novo_clock = 0;
    cyc(2);
    key_start_n = 0;
    tick_n(3);
    key_start_n = 1;
    tick_n(2);
    checks++; if (dut_vec !== 18'd0) begin errors++; $display("FAIL clear_held: got %h expected 0", dut_vec); end
    key_clear_n = 1;
    cyc(S + 3);
    checks++; if (dut_vec !== 18'd0) begin errors++; $display("FAIL clear_release: got %h expected 0", dut_vec); end
    checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL clear_model: got %h expected %h", dut_vec, exp_vec()); end
  endtask
  task automatic test_held_start();
    int rises;
    logic prev;
    rises = 0;
    prev = running;
    key_start_n = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1);
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL held_cycle%0d: got %h expected %h", i, dut_vec, exp_vec()); end
      if (running === 1'b1 && prev === 1'b0) rises++;
      prev = running;
    end
    checks++; if (rises != 1) begin errors++; $display("FAIL held_rises: got %0d expected 1", rises); end
    key_start_n = 1;
    cyc(20);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL held_release: got %b expected 1", running); end
  endtask
  task automatic test_random();
    logic [17:0] prev;
    logic [27:0] hexp;
    prev = '0;
    for (int i = 0; i < 4000; i++) begin
      cyc(1);
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec, exp_vec()); end
`ifdef SEVEN_SEG_EN
      hexp = {SEG7[prev[17:14]], SEG7[prev[13:10]], SEG7[prev[9:6]], SEG7[prev[5:2]]};
`else
      hexp = {4{7'h7F}};
`endif
      if (i > 0) begin
        checks++; if (dut_hex !== hexp) begin errors++; $display("FAIL random_hex%0d: got %h expected %h", i, dut_hex, hexp); end
      end
      prev = exp_vec();
      if ($urandom_range(0, 3) == 0) novo_clock = ~novo_clock;
      if ($urandom_range(0, 15) == 0) key_start_n = ~key_start_n;
      key_clear_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
    end
  endtask
  task automatic test_reset_mid();
    novo_clock = 0;
    key_start_n = 1;
    key_clear_n = 1;
    cyc(4);
    do_clear();
    press_start();
    tick_n(5);
    cyc(S + 1);
    checks++; if (dut_vec !== {4'd0, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0}) begin errors++; $display("FAIL midreset_pre: got %h expected %h", dut_vec, {4'd0, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0}); end
    #2 reset = 0;
    #1;
    checks++; if (dut_vec !== 18'd0) begin errors++; $display("FAIL midreset_async: got %h expected 0", dut_vec); end
    checks++; if (dut_hex !== HEX_ZERO) begin errors++; $display("FAIL midreset_hex: got %h expected %h", dut_hex, HEX_ZERO); end
    cyc(2);
    reset = 1;
    tick_n(2);
    cyc(S + 1);
    checks++; if (dut_vec !== 18'd0) begin errors++; $display("FAIL midreset_after: got %h expected 0", dut_vec); end
    checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL midreset_model: got %h expected %h", dut_vec, exp_vec()); end
    checks++; if (dut_hex !== HEX_ZERO) begin errors++; $display("FAIL midreset_hex_after: got %h expected %h", dut_hex, HEX_ZERO); end
  endtask
  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_pause_tick();
    test_clear();
    test_held_start();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
